cle_bit_collector: RTL and testbench

CLE_BIT_COLLECTOR -- requirements
Module: cle_bit_collector

---
 rtl/cle_bit_collector.sv | 125 ++++++++++++
 tb/tb_cle_bit_collector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cle_bit_collector.sv
`default_nettype none
// ============================================================================
// cle_bit_collector : collects NBITS lock-response bits from qualified bus
// reads and compares the result against SIG.                    Rev 1.0
// ============================================================================
module cle_bit_collector #(
  parameter int               NBITS   = 16,
  parameter logic [NBITS-1:0] SIG     = 16'hA5C3,
  parameter int               TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SSER,
  input  logic             BA13,
  input  logic             BA12,
  input  logic             BR_W,
  input  logic             SDRD,
  input  logic             arm,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic             err,
  output logic [NBITS-1:0] data,
  output logic [5:0]       bit_cnt
);

  localparam int         TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [5:0] NB       = 6'(NBITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t        state;
  logic          qr_d1, qr_d2, qr_d3;
  logic          sdrd_d1, sdrd_d2;
  logic          bit_q;
  logic [2:0]    vld;
  logic [TW-1:0] tcnt;
  logic          qr;
  logic          rd_ev;

  assign qr = ~SSER & ~BA13 & BA12 & BR_W;

  // vld[2] marks qr_d3 as a genuine post-reset sample, so a read already in
  // progress when reset is released cannot look like a fresh rising edge.
  assign rd_ev = qr_d2 & ~qr_d3 & vld[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      qr_d1   <= 1'b0;
      qr_d2   <= 1'b0;
      qr_d3   <= 1'b0;
      sdrd_d1 <= 1'b0;
      sdrd_d2 <= 1'b0;
      bit_q   <= 1'b0;
      vld     <= 3'b000;
      tcnt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      match   <= 1'b0;
      err     <= 1'b0;
      data    <= '0;
      bit_cnt <= '0;
    end else begin
      qr_d1   <= qr;
      qr_d2   <= qr_d1;
      qr_d3   <= qr_d2;
      sdrd_d1 <= SDRD;
      sdrd_d2 <= sdrd_d1;
      vld     <= {vld[1:0], 1'b1};
      done    <= 1'b0;

      if (arm) begin
        state   <= ARMED;
        data    <= '0;
        bit_cnt <= '0;
        err     <= 1'b0;
        match   <= 1'b0;
        tcnt    <= '0;
        busy    <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          ARMED: begin
            if (rd_ev) begin
              bit_q <= sdrd_d2;
              tcnt  <= '0;
              state <= CAPTURE;
            end else if (tcnt == T_LAST) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          CAPTURE: begin
            data <= {data[NBITS-2:0], bit_q};
            if (bit_cnt < NB) bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt >= NB - 6'd1) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              state <= ARMED;
            end
          end
          FINISH: begin
            match <= (data == SIG) & ~err;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cle_bit_collector.sv
`default_nettype none
// Directed self-checking bench for cle_bit_collector.
`timescale 1ns/1ps
module tb_cle_bit_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SSER = 1'b1, BA13 = 1'b0, BA12 = 1'b0, BR_W = 1'b0, SDRD = 1'b0;
  logic        arm = 1'b0;
  logic        busy, done, match, err;
  logic [15:0] data;
  logic [5:0]  bit_cnt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;

  cle_bit_collector dut (
    .clk(clk), .rst_n(rst_n), .SSER(SSER), .BA13(BA13), .BA12(BA12),
    .BR_W(BR_W), .SDRD(SDRD), .arm(arm), .busy(busy), .done(done),
    .match(match), .err(err), .data(data), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step(1);
    arm = 1'b0;
  endtask

  task automatic bus_idle();
    SSER = 1'b1; BA13 = 1'b0; BA12 = 1'b0; BR_W = 1'b0; SDRD = 1'b0;
  endtask

  task automatic bus_read(input logic b, input int len, input logic a13);
    SSER = 1'b0; BA13 = a13; BA12 = 1'b1; BR_W = 1'b1; SDRD = b;
    step(len);
    bus_idle();
    step(6);
  endtask

  task automatic read_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) bus_read(w[i], 1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_err", err, 0);
    check("rst_data", data, 0);
    check("rst_bitcnt", bit_cnt, 0);
    rst_n = 1'b1;
    step(3);
    check("idle_busy", busy, 0);

    // Sequence 1: exact signature, first bit with latency check
    d0 = done_cnt;
    pulse_arm();
    check("armed_busy", busy, 1);
    SSER = 1'b0; BA12 = 1'b1; BR_W = 1'b1; SDRD = 1'b1;
    step(1);
    bus_idle();
    step(2);
    check("lat_early_data", data, 16'h0000);
    step(1);
    check("lat_data", data, 16'h0001);
    check("lat_bitcnt", bit_cnt, 1);
    step(3);
    read_bits(16'hA5C3, 15);
    step(2);
    check("sig_done", done_cnt, d0 + 1);
    check("sig_data", data, 16'hA5C3);
    check("sig_bitcnt", bit_cnt, 16);
    check("sig_match", match, 1);
    check("sig_err", err, 0);
    check("sig_busy", busy, 0);

    bus_read(1'b0, 1, 1'b0);
    check("idle_ign_data", data, 16'hA5C3);
    check("idle_ign_bitcnt", bit_cnt, 16);
    check("idle_hold_match", match, 1);

    // Sequence 2: bit 0 flipped
    d0 = done_cnt;
    pulse_arm();
    check("rearm_match_clr", match, 0);
    read_bits(16'hA5C2, 16);
    step(2);
    check("bad_done", done_cnt, d0 + 1);
    check("bad_data", data, 16'hA5C2);
    check("bad_match", match, 0);
    check("bad_err", err, 0);

    // Sequence 3: timeout after 3 bits
    d0 = done_cnt;
    pulse_arm();
    read_bits(16'h0005, 3);
    step(900);
    check("to_early_err", err, 0);
    check("to_early_busy", busy, 1);
    for (int i = 0; i < 300 && done_cnt == d0; i++) step(1);
    check("to_done", done_cnt, d0 + 1);
    step(2);
    check("to_err", err, 1);
    check("to_match", match, 0);
    check("to_bitcnt", bit_cnt, 3);
    check("to_busy", busy, 0);
    check("to_data", data, 16'h0005);

    // Long read gives one bit; BA13=1 gives none
    pulse_arm();
    check("arm_clr_err", err, 0);
    bus_read(1'b1, 10, 1'b0);
    check("long_bitcnt", bit_cnt, 1);
    check("long_data", data, 16'h0001);
    bus_read(1'b1, 1, 1'b1);
    check("ba13_bitcnt", bit_cnt, 1);

    // Restart mid-sequence
    pulse_arm();
    read_bits(16'h001F, 5);
    check("rs_pre_bitcnt", bit_cnt, 5);
    d0 = done_cnt;
    pulse_arm();
    step(1);
    check("rs_bitcnt", bit_cnt, 0);
    check("rs_data", data, 0);
    check("rs_no_done", done_cnt, d0);
    check("rs_busy", busy, 1);
    read_bits(16'hA5C3, 16);
    step(2);
    check("rs_done", done_cnt, d0 + 1);
    check("rs_match", match, 1);

    // Reset mid-read, released while qr still high
    pulse_arm();
    read_bits(16'h007F, 7);
    check("pr_bitcnt", bit_cnt, 7);
    SSER = 1'b0; BA12 = 1'b1; BR_W = 1'b1; SDRD = 1'b1;
    step(3);
    rst_n = 1'b0;
    #2;
    check("ar_busy", busy, 0);
    check("ar_bitcnt", bit_cnt, 0);
    check("ar_data", data, 0);
    check("ar_match", match, 0);
    check("ar_err", err, 0);
    check("ar_done", done, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    pulse_arm();
    step(6);
    check("ar_nocap_bitcnt", bit_cnt, 0);
    check("ar_nocap_data", data, 0);
    check("ar_armed_busy", busy, 1);
    bus_idle();
    step(4);
    bus_read(1'b1, 1, 1'b0);
    check("ar_new_bitcnt", bit_cnt, 1);
    check("ar_new_data", data, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
